// File: rtl/cpu_pkg.sv
// Shared CPU constants: RAM geometry and control-word bit positions.
// Imported by the program memory, its bus interface and the bench.
package cpu_pkg;
    localparam int ADDR_W    = 4;
    localparam int RAM_BYTES = 16;

    localparam int CW_NLMA = 11;
    localparam int CW_NLMD = 10;
    localparam int CW_NCE  = 9;
    localparam int CW_NLR  = 8;

    typedef logic [7:0] byte_t;
endpackage

// File: rtl/program_memory_if.sv
// Shared-bus side of the program memory: bus data plus the four
// active-low control-word strobes that steer it in run mode.
interface program_memory_if;
    import cpu_pkg::*;

    byte_t bus_in;
    byte_t bus_out;
    logic  bus_oe;
    logic  n_lma;
    logic  n_lmd;
    logic  n_ce;
    logic  n_lr;

    modport master (
        output bus_in, n_lma, n_lmd, n_ce, n_lr,
        input  bus_out, bus_oe
    );

    modport slave (
        input  bus_in, n_lma, n_lmd, n_ce, n_lr,
        output bus_out, bus_oe
    );
endinterface

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous pin, plus a delay flop
// so a one-cycle pulse marks each synchronized rising edge.
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic level,
    output logic rise
);
    logic s1;
    logic s2;
    logic d;

    // Metastability chain followed by the edge-detect history flop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            d  <= 1'b0;
        end else begin
            s1 <= async_in;
            s2 <= s1;
            d  <= s2;
        end
    end

    assign level = s2;
    assign rise  = s2 & ~d;
endmodule

// File: rtl/program_memory.sv
// MAR, MDR and flip-flop RAM on the shared bus, with a loader that
// fills the RAM from dedicated pins while the CPU is held.
module program_memory #(
    parameter int RAM_BYTES = cpu_pkg::RAM_BYTES,
    parameter int ADDR_W    = cpu_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    program_memory_if.slave   bus,
    input  logic              prog_mode,
    input  logic [7:0]        prog_data,
    input  logic              prog_strobe,
    output logic [ADDR_W-1:0] prog_addr,
    output logic              prog_done,
    output logic              cpu_hold
);
    logic [ADDR_W-1:0] mar;
    logic [7:0]        mdr;
    logic [7:0]        mem [RAM_BYTES];
    logic              pm_s;
    logic              pm_rise;
    logic              pm_q;
    logic              st_s;
    logic              st_rise;

    sync_edge u_pm_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (prog_mode),
        .level    (pm_s),
        .rise     (pm_rise)
    );

    sync_edge u_st_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (prog_strobe),
        .level    (st_s),
        .rise     (st_rise)
    );

    // Loader writes while held; one cleanup cycle on exit; else run mode.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mar       <= '0;
            mdr       <= '0;
            prog_addr <= '0;
            prog_done <= 1'b0;
            pm_q      <= 1'b0;
            for (int i = 0; i < RAM_BYTES; i++) begin
                mem[i] <= '0;
            end
        end else begin
            pm_q <= pm_s;
            if (pm_s) begin
                if (pm_rise) begin
                    prog_addr <= '0;
                    prog_done <= 1'b0;
                end else if (st_rise && !prog_done) begin
                    mem[prog_addr] <= prog_data;
                    prog_addr      <= prog_addr + 1'b1;
                    if (prog_addr == ADDR_W'(RAM_BYTES - 1)) begin
                        prog_done <= 1'b1;
                    end
                end
            end else if (pm_q) begin
                prog_addr <= '0;
                prog_done <= 1'b0;
                mar       <= '0;
            end else begin
                if (!bus.n_lr) begin
                    mem[mar] <= mdr;
                end
                if (!bus.n_lma) begin
                    mar <= bus.bus_in[ADDR_W-1:0];
                end
                if (!bus.n_lmd) begin
                    mdr <= bus.bus_in;
                end
            end
        end
    end

    assign bus.bus_out = mem[mar];
    assign bus.bus_oe  = ~bus.n_ce & ~pm_s;
    assign cpu_hold    = pm_s;

    // The level of the strobe is only needed for its edge.
    logic unused_st;
    assign unused_st = st_s;
endmodule

// File: tb/tb_program_memory.sv
// Randomized bench for program_memory against a byte-array model of
// the MAR/MDR/RAM rules and the loader's address/done bookkeeping.
module tb_program_memory;
    import cpu_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       prog_mode;
    logic [7:0] prog_data;
    logic       prog_strobe;
    logic [3:0] prog_addr;
    logic       prog_done;
    logic       cpu_hold;

    program_memory_if bus ();

    program_memory dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .prog_mode   (prog_mode),
        .prog_data   (prog_data),
        .prog_strobe (prog_strobe),
        .prog_addr   (prog_addr),
        .prog_done   (prog_done),
        .cpu_hold    (cpu_hold)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] ref_mem [16];
    int         ref_mar;
    logic [7:0] ref_mdr;
    int         ref_paddr;
    bit         ref_done;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.n_lma  = 1'b1;
        bus.n_lmd  = 1'b1;
        bus.n_lr   = 1'b1;
        bus.n_ce   = 1'b1;
        bus.bus_in = 8'h00;
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One run-mode cycle: check outputs before the edge, then apply
    // the write (old MAR/MDR) followed by the register loads.
    task automatic run_op(bit lma, bit lmd, bit lr, bit ce,
                          logic [7:0] data);
        bus.n_lma  = ~lma;
        bus.n_lmd  = ~lmd;
        bus.n_lr   = ~lr;
        bus.n_ce   = ~ce;
        bus.bus_in = data;
        #1;
        chk("bus_out", 32'(bus.bus_out), 32'(ref_mem[ref_mar]));
        chk("bus_oe", 32'(bus.bus_oe), 32'(ce));
        @(posedge clk);
        if (lr) ref_mem[ref_mar] = ref_mdr;
        if (lma) ref_mar = int'(data[3:0]);
        if (lmd) ref_mdr = data;
        @(negedge clk);
        idle();
    endtask

    task automatic rand_ops(int n);
        for (int i = 0; i < n; i++) begin
            run_op(1'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom), 8'($urandom));
        end
    endtask

    task automatic read_all();
        for (int i = 0; i < 16; i++) begin
            run_op(1'b1, 1'b0, 1'b0, 1'b0, 8'(i));
        end
        run_op(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        idle();
        cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
        ref_mar   = 0;
        ref_mdr   = 8'h00;
        ref_paddr = 0;
        ref_done  = 1'b0;
    endtask

    task automatic enter_loader();
        prog_mode = 1'b1;
        for (int i = 0; i < 3; i++) cyc();
        ref_paddr = 0;
        ref_done  = 1'b0;
        chk("hold_in", 32'(cpu_hold), 32'd1);
    endtask

    // Strobe 2 cycles high, 2 low; run strobes are noise that must be
    // ignored and bus_oe must stay low with n_ce asserted.
    task automatic strobe(logic [7:0] v);
        prog_data = v;
        for (int i = 0; i < 4; i++) begin
            prog_strobe = (i < 2);
            bus.n_lma  = 1'($urandom);
            bus.n_lmd  = 1'($urandom);
            bus.n_lr   = 1'($urandom);
            bus.n_ce   = 1'b0;
            bus.bus_in = 8'($urandom);
            #1;
            chk("oe_load", 32'(bus.bus_oe), 32'd0);
            cyc();
        end
        idle();
        if (!ref_done) begin
            ref_mem[ref_paddr] = v;
            ref_paddr = (ref_paddr + 1) % 16;
            if (ref_paddr == 0) ref_done = 1'b1;
        end
        chk("paddr", 32'(prog_addr), 32'(ref_paddr));
        chk("pdone", 32'(prog_done), 32'(ref_done));
    endtask

    task automatic exit_loader();
        prog_mode = 1'b0;
        idle();
        cyc();
        chk("hold_1", 32'(cpu_hold), 32'd1);
        cyc();
        chk("hold_2", 32'(cpu_hold), 32'd0);
        cyc();
        ref_mar   = 0;
        ref_paddr = 0;
        ref_done  = 1'b0;
        chk("paddr_x", 32'(prog_addr), 32'd0);
        chk("pdone_x", 32'(prog_done), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        prog_mode   = 1'b0;
        prog_data   = 8'h00;
        prog_strobe = 1'b0;
        idle();
        @(negedge clk);
        reset_dut();
        chk("rst_out", 32'(bus.bus_out), 32'd0);
        chk("rst_oe", 32'(bus.bus_oe), 32'd0);
        chk("rst_done", 32'(prog_done), 32'd0);
        chk("rst_addr", 32'(prog_addr), 32'd0);
        chk("rst_hold", 32'(cpu_hold), 32'd0);

        rand_ops(60);
        read_all();
        reset_dut();
        chk("rst2_oe", 32'(bus.bus_oe), 32'd0);
        read_all();

        run_op(1'b1, 1'b0, 1'b0, 1'b0, 8'h05);
        run_op(1'b0, 1'b1, 1'b0, 1'b0, 8'hA7);
        run_op(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        bus.n_ce = 1'b0;
        #1;
        chk("wr_rd", 32'(bus.bus_out), 32'h0A7);
        chk("wr_oe", 32'(bus.bus_oe), 32'd1);
        cyc();
        idle();

        run_op(1'b1, 1'b1, 1'b0, 1'b0, 8'h09);
        run_op(1'b0, 1'b1, 1'b1, 1'b0, 8'h5C);
        run_op(1'b1, 1'b1, 1'b1, 1'b0, 8'h03);
        run_op(1'b0, 1'b1, 1'b0, 1'b0, 8'h11);
        run_op(1'b1, 1'b0, 1'b1, 1'b1, 8'h09);
        bus.n_ce = 1'b0;
        #1;
        chk("sim_mar9", 32'(bus.bus_out), 32'h05C);
        cyc();
        run_op(1'b1, 1'b0, 1'b0, 1'b1, 8'h03);
        bus.n_ce = 1'b0;
        #1;
        chk("sim_mem3", 32'(bus.bus_out), 32'h011);
        cyc();
        idle();
        run_op(1'b1, 1'b1, 1'b1, 1'b1, 8'h21);
        run_op(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);

        enter_loader();
        for (int i = 0; i < 16; i++) strobe(8'(8'h10 + i));
        chk("full_done", 32'(prog_done), 32'd1);
        chk("full_addr", 32'(prog_addr), 32'd0);
        strobe(8'hEE);
        exit_loader();
        read_all();

        enter_loader();
        for (int i = 0; i < 5; i++) strobe(8'($urandom));
        exit_loader();
        read_all();
        rand_ops(40);
        read_all();

        enter_loader();
        for (int i = 0; i < 3; i++) strobe(8'($urandom));
        reset_dut();
        for (int i = 0; i < 3; i++) cyc();
        chk("rl_hold", 32'(cpu_hold), 32'd1);
        for (int i = 0; i < 2; i++) strobe(8'($urandom));
        exit_loader();
        read_all();
        rand_ops(30);
        read_all();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
